// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the cpu_seq program sequencer: FSM states and branch types.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_JMPB = 3'd2,
    BR_JZ   = 3'd3,
    BR_JC   = 3'd4,
    BR_CALL = 3'd5,
    BR_RET  = 3'd6,
    BR_HALT = 3'd7
  } br_e;

endpackage

// File: rtl/cpu_seq_stack.sv
// Return-address LIFO of STACK_DEPTH x AWIDTH; push and pop are mutually exclusive.
module cpu_seq_stack
  import cpu_seq_pkg::*;
#(
  parameter int AWIDTH      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [AWIDTH-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH-1:0] top
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0]    sp_q, sp_d;
  logic [AWIDTH-1:0] mem_q [STACK_DEPTH];
  logic [AWIDTH-1:0] mem_d [STACK_DEPTH];

  assign full  = (sp_q == SPW'(STACK_DEPTH));
  assign empty = (sp_q == {SPW{1'b0}});
  // sp_q counts entries, so the newest entry lives one below it
  assign top   = mem_q[IW'(sp_q - SPW'(1'b1))];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clr) begin
      sp_d = {SPW{1'b0}};
    end else if (push && !full) begin
      mem_d[IW'(sp_q)] = din;
      sp_d             = sp_q + SPW'(1'b1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1'b1);
    end else begin
      sp_d = sp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= {SPW{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= {AWIDTH{1'b0}};
      end
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle program sequencer: FETCH/WAIT/EXEC with jumps, CALL/RET and HALT.
// Optional fetch-wait timeout enabled by defining CPU_SEQ_TIMEOUT_EN.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int                WIDTH       = 13,
  parameter int                IWIDTH      = 5,
  parameter int                AWIDTH      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [AWIDTH-1:0] RST_VEC     = {AWIDTH{1'b0}},
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              IMEM_REQ,
  output logic [AWIDTH-1:0] IMEM_ADDR,
  input  logic [WIDTH-1:0]  IMEM_RDATA,
  input  logic              IMEM_RVALID,
  output logic [WIDTH-1:0]  INSTR,
  output logic              INSTR_VALID,
  input  logic              STALL,
  input  logic [2:0]        BR_TYPE,
  input  logic [AWIDTH-1:0] BR_ADDR,
  input  logic              BASE_LD,
  input  logic [AWIDTH-1:0] BASE_DATA,
  input  logic              FLAG_Z,
  input  logic              FLAG_C,
  output logic [AWIDTH-1:0] PC,
  output logic              HALTED,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  if (IWIDTH >= WIDTH || AWIDTH > WIDTH || STACK_DEPTH < 1 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("cpu_seq: inconsistent parameter set");
  end

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, base_q, base_d, pc_inc_s;
  logic [WIDTH-1:0]  instr_q, instr_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              req_q, req_d, ivld_q, ivld_d, halted_q, halted_d;
  logic              stk_push_s, stk_pop_s, stk_clr_s, stk_full_s, stk_empty_s;
  logic [AWIDTH-1:0] stk_top_s;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
`endif

  assign pc_inc_s = pc_q + AWIDTH'(1'b1);

  cpu_seq_stack #(
    .AWIDTH      (AWIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (stk_clr_s),
    .push  (stk_push_s),
    .pop   (stk_pop_s),
    .din   (pc_inc_s),
    .full  (stk_full_s),
    .empty (stk_empty_s),
    .top   (stk_top_s)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    base_d     = base_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stk_push_s = 1'b0;
    stk_pop_s  = 1'b0;
    stk_clr_s  = 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          pc_d    = RST_VEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
`ifdef CPU_SEQ_TIMEOUT_EN
        wcnt_d  = {TW{1'b0}};
`endif
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          instr_d = IMEM_RDATA;
          state_d = S_EXEC;
        end else begin
`ifdef CPU_SEQ_TIMEOUT_EN
          // give up on a silent memory and re-issue the same address
          if (wcnt_q == TO_LAST) begin
            state_d = S_FETCH;
          end else begin
            wcnt_d  = wcnt_q + TW'(1'b1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_EXEC: begin
        if (STALL) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
          if (BASE_LD) begin
            base_d = BASE_DATA;
          end else begin
            base_d = base_q;
          end
          case (br_e'(BR_TYPE))
            BR_NONE: pc_d = pc_inc_s;
            BR_JMP:  pc_d = BR_ADDR;
            BR_JMPB: pc_d = base_q + BR_ADDR;
            BR_JZ:   pc_d = FLAG_Z ? BR_ADDR : pc_inc_s;
            BR_JC:   pc_d = FLAG_C ? BR_ADDR : pc_inc_s;
            BR_CALL: begin
              if (stk_full_s) begin
                ovf_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                stk_push_s = 1'b1;
                pc_d       = BR_ADDR;
              end
            end
            BR_RET: begin
              if (stk_empty_s) begin
                unf_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                stk_pop_s = 1'b1;
                pc_d      = stk_top_s;
              end
            end
            BR_HALT: state_d = S_HALT;
            default: pc_d = pc_inc_s;
          endcase
        end
      end
      S_HALT: begin
        if (START) begin
          state_d   = S_FETCH;
          pc_d      = RST_VEC;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          stk_clr_s = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // status outputs are registered from the next state so they align with it
    req_d    = (state_d == S_FETCH);
    ivld_d   = (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= RST_VEC;
      instr_q  <= {WIDTH{1'b0}};
      base_q   <= {AWIDTH{1'b0}};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      req_q    <= 1'b0;
      ivld_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
      wcnt_q   <= {TW{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      base_q   <= base_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      req_q    <= req_d;
      ivld_q   <= ivld_d;
      halted_q <= halted_d;
`ifdef CPU_SEQ_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = ivld_q;
  assign HALTED      = halted_q;
  assign STK_OVF     = ovf_q;
  assign STK_UNF     = unf_q;

endmodule
